mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  - MEM stage of the rv32i pipeline. Sits between EX and writeback.
//  - Issues loads and stores to the data memory port and waits for dmem_resp.
//  - Registers a stage_regs bundle plus the raw 32-bit load word for writeback.
//  - Writeback performs byte/half extraction; this block only aligns store data
//    and byte enables.
// PARAMETERS
//  width  32  data/address width; only 32 supported
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst           in   1      synchronous, active-high reset
//  regs_in       in   stage_regs  EX/MEM bundle (alu = effective addr, rs2 = store value, funct3, ctrl)
//  valid_in      in   1      regs_in holds a real instruction
//  stall_out     out  1      upstream must hold regs_in/valid_in stable while high
//  dmem_read     out  1      load request
//  dmem_write    out  1      store request
//  dmem_address  out  32     word-aligned address ({alu[31:2],2'b00})
//  dmem_wmask    out  4      store byte enables
//  dmem_wdata    out  32     store data, lane-aligned
//  dmem_rdata    in   32     load word, sampled when dmem_resp=1
//  dmem_resp     in   1      one-cycle completion pulse for the current request
//  regs_out      out  stage_regs  MEM/WB bundle to writeback
//  rdata_out     out  32     raw load word to writeback (its rdata_b)
//  valid_out     out  1      regs_out valid this cycle
// BEHAVIOUR
//  - Reset: state=IDLE. valid_out, stall_out, dmem_read, dmem_write = 0.
//    dmem_wmask, dmem_address, dmem_wdata, rdata_out = 0. regs_out = '0.
//  - mem_op = valid_in & (ctrl.opcode==op_load | ctrl.opcode==op_store).
//  - IDLE:
//    - valid_in & ~mem_op: regs_out<=regs_in, valid_out<=1. Latency 1 cycle.
//    - mem_op: latch regs_in into hold register, state<=BUSY, valid_out<=0.
//    - ~valid_in: valid_out<=0.
//  - BUSY:
//    - stall_out=1 for every cycle in BUSY, including the resp cycle.
//    - dmem_read/dmem_write are driven from the hold register, held constant
//      until dmem_resp.
//    - On dmem_resp: regs_out<=hold, rdata_out<=dmem_rdata (loads; stores leave it
//      unchanged), valid_out<=1, state<=IDLE.
//    - Best case: accepted at T, resp at T+1, valid_out at T+2.
//  - No new instruction is accepted in BUSY. The held EX instruction is accepted
//    in the first IDLE cycle after resp.
//  - Bubble rule: whenever valid_out=0, regs_out.ctrl.load_regfile must be 0, so
//    writeback never writes the regfile on a bubble.
//  - valid_out is a one-cycle pulse per instruction. regs_out/rdata_out hold
//    their value until the next update.
//  - Store alignment, off = alu[1:0]:
//    - sb: wmask = 4'b0001<<off, wdata = rs2<<(8*off).
//    - sh: wmask = 4'b0011<<off, wdata = rs2<<(8*off). Bits shifted past lane 3
//      are dropped (sh at off=3 gives 4'b1000).
//    - sw: wmask = 4'b1111, wdata = rs2; off is ignored.
//    - Loads: wmask = 4'b0000.
//  - dmem_read and dmem_write are never high together, and never high outside BUSY.
//  - rst in BUSY: next cycle IDLE with requests deasserted and the instruction
//    dropped. The memory side must tolerate an abandoned request.
//  - dmem_resp while in IDLE is ignored.
// STRUCTURE
//  - rv32i_types holds stage_regs, rv32i_opcode (op_load, op_store),
//    store_funct3_t (sb/sh/sw) and the enum mem_state_t {IDLE, BUSY}.
//  - Sub-module store_align: funct3, alu[1:0], rs2 -> dmem_wmask, dmem_wdata.
//    Combinational.
//  - FSM, hold register and MEM/WB register are written inline.
// TESTING
//  1. Non-mem op, alu=0x10, valid_in 1 cycle -> valid_out=1 next cycle;
//     regs_out.alu=0x10; no dmem strobe.
//  2. lw, alu=0x104; resp after 3 BUSY cycles with 0xDEADBEEF ->
//     dmem_read=1 for 3 cycles at addr 0x104, stall_out=1 throughout;
//     valid_out 1 cycle after resp; rdata_out=0xDEADBEEF.
//  3. sb, alu=0x1003, rs2=0x000000AB -> addr 0x1000, wmask 4'b1000,
//     wdata 0xAB000000, dmem_write=1 only.
//  4. sh, alu=0x2002, rs2=0x00001234 -> addr 0x2000, wmask 4'b1100,
//     wdata 0x12340000.
//  5. lw followed by add, add held while stalled -> add accepted 1 cycle after
//     resp; exactly two valid_out pulses, in order; load_regfile=0 on all bubbles.
//  6. rst during BUSY -> next cycle dmem_read=0, valid_out=0, stall_out=0;
//     a later resp pulse produces no valid_out.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared rv32i pipeline types: opcodes, store funct3 codes,
//                control word, inter-stage register bundle, MEM FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  localparam int unsigned c_xlen = 32;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
  } rv32i_control_word;

  typedef struct packed {
    logic [c_xlen-1:0] pc;
    logic [c_xlen-1:0] alu;
    logic [c_xlen-1:0] rs2;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    rv32i_control_word ctrl;
  } stage_regs;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // True for the two opcodes that need a data-memory transaction.
  function automatic logic is_mem_opcode(input rv32i_opcode op);
    return (op == op_load) || (op == op_store);
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_align
//  Description : Places store data on the correct byte lanes of the 32-bit
//                data bus and produces the matching byte enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  logic [4:0] w_bit_shift;

  assign w_bit_shift = {off, 3'b000};

  // Lane mask and shifted data; bytes pushed past lane 3 simply fall off.
  always_comb begin
    wmask = 4'b0000;
    wdata = '0;
    case (funct3)
      sb: begin
        wmask = 4'b0001 << off;
        wdata = rs2 << w_bit_shift;
      end
      sh: begin
        wmask = 4'b0011 << off;
        wdata = rs2 << w_bit_shift;
      end
      sw: begin
        wmask = 4'b1111;
        wdata = rs2;
      end
      default: begin
        wmask = 4'b0000;
        wdata = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : rv32i MEM stage. Issues loads/stores to the data memory port,
//                stalls upstream while a request is outstanding, and registers
//                the MEM/WB bundle plus the raw load word for writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_regs        regs_in,
  input  logic             valid_in,
  output logic             stall_out,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [3:0]       dmem_wmask,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output stage_regs        regs_out,
  output logic [WIDTH-1:0] rdata_out,
  output logic             valid_out
);

  mem_state_t       r_state;
  mem_state_t       w_state_next;
  stage_regs        r_hold;
  stage_regs        r_regs_out;
  logic [WIDTH-1:0] r_rdata_out;
  logic             r_valid_out;

  logic             w_mem_op;
  logic             w_busy;
  logic             w_hold_load;
  logic             w_hold_store;
  logic [3:0]       w_align_wmask;
  logic [WIDTH-1:0] w_align_wdata;

  assign w_mem_op     = valid_in & is_mem_opcode(regs_in.ctrl.opcode);
  assign w_busy       = (r_state == BUSY);
  assign w_hold_load  = (r_hold.ctrl.opcode == op_load);
  assign w_hold_store = (r_hold.ctrl.opcode == op_store);

  store_align u_store_align (
    .funct3 (r_hold.funct3),
    .off    (r_hold.alu[1:0]),
    .rs2    (r_hold.rs2),
    .wmask  (w_align_wmask),
    .wdata  (w_align_wdata)
  );

  // Next state: leave IDLE on a memory instruction, return on the response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mem_op)  w_state_next = BUSY;
      BUSY:    if (dmem_resp) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Hold register captures the memory instruction for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (!w_busy && w_mem_op) begin
      r_hold <= regs_in;
    end
  end

  // MEM/WB register: non-memory ops pass in one cycle, memory ops on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs_out  <= '0;
      r_rdata_out <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (!w_busy) begin
        if (valid_in && !w_mem_op) begin
          r_regs_out  <= regs_in;
          r_valid_out <= 1'b1;
        end
      end else if (dmem_resp) begin
        r_regs_out  <= r_hold;
        r_valid_out <= 1'b1;
        if (w_hold_load) begin
          r_rdata_out <= dmem_rdata;
        end
      end
    end
  end

  // Memory port is only active in BUSY; everything else idles at zero.
  always_comb begin
    stall_out    = w_busy;
    dmem_read    = w_busy & w_hold_load;
    dmem_write   = w_busy & w_hold_store;
    dmem_address = w_busy ? {r_hold.alu[WIDTH-1:2], 2'b00} : '0;
    dmem_wmask   = (w_busy & w_hold_store) ? w_align_wmask : 4'b0000;
    dmem_wdata   = (w_busy & w_hold_store) ? w_align_wdata : '0;
  end

  // Bundle holds its contents, but a bubble must never write the regfile.
  always_comb begin
    regs_out                   = r_regs_out;
    regs_out.ctrl.load_regfile = r_regs_out.ctrl.load_regfile & r_valid_out;
    rdata_out                  = r_rdata_out;
    valid_out                  = r_valid_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Directed self-checking bench for the rv32i MEM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  stage_regs   regs_in;
  logic        valid_in;
  logic        stall_out;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  stage_regs   regs_out;
  logic [31:0] rdata_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  mem_access #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .regs_in      (regs_in),
    .valid_in     (valid_in),
    .stall_out    (stall_out),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .regs_out     (regs_out),
    .rdata_out    (rdata_out),
    .valid_out    (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stage_regs make_regs(input rv32i_opcode op, input logic [31:0] alu,
                                          input logic [31:0] rs2, input logic [2:0] f3,
                                          input logic lrf);
    stage_regs r;
    r = '0;
    r.pc                = 32'h0000_0400;
    r.alu               = alu;
    r.rs2               = rs2;
    r.funct3            = f3;
    r.rd                = 5'd7;
    r.ctrl.opcode       = op;
    r.ctrl.load_regfile = lrf;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; regs_in = '0; dmem_resp = 1'b0; dmem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
    checks++; if ({dmem_read, dmem_write} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b expected 00", {dmem_read, dmem_write}); end
    checks++; if (dmem_address !== 32'h0 || dmem_wmask !== 4'h0 || dmem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_port: addr %h mask %b wdata %h expected all 0", dmem_address, dmem_wmask, dmem_wdata); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_out); end
    checks++; if (regs_out !== '0) begin errors++; $display("FAIL reset_regs_out: got %h expected 0", regs_out); end
  endtask

  task automatic test_non_mem();
    regs_in  = make_regs(op_reg, 32'h10, 32'h0, 3'b000, 1'b1);
    valid_in = 1'b1;
    #1;
    checks++; if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin errors++; $display("FAIL nonmem_strobe: got %b expected 000", {dmem_read, dmem_write, stall_out}); end
    tick();
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL nonmem_valid: got %b expected 1", valid_out); end
    checks++; if (regs_out.alu !== 32'h10) begin errors++; $display("FAIL nonmem_alu: got %h expected 00000010", regs_out.alu); end
    checks++; if (regs_out.ctrl.load_regfile !== 1'b1) begin errors++; $display("FAIL nonmem_lrf: got %b expected 1", regs_out.ctrl.load_regfile); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL nonmem_pulse: got %b expected 0", valid_out); end
    checks++; if (regs_out.ctrl.load_regfile !== 1'b0) begin errors++; $display("FAIL nonmem_bubble_lrf: got %b expected 0", regs_out.ctrl.load_regfile); end
    checks++; if (regs_out.alu !== 32'h10) begin errors++; $display("FAIL nonmem_hold: got %h expected 00000010", regs_out.alu); end
  endtask

  task automatic test_load();
    regs_in  = make_regs(op_load, 32'h104, 32'h0, 3'b010, 1'b1);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dmem_read, dmem_write} !== 2'b10) begin errors++; $display("FAIL load_req[%0d]: got %b expected 10", i, {dmem_read, dmem_write}); end
      checks++; if (dmem_address !== 32'h104) begin errors++; $display("FAIL load_addr[%0d]: got %h expected 00000104", i, dmem_address); end
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL load_stall[%0d]: got %b expected 1", i, stall_out); end
      checks++; if (dmem_wmask !== 4'b0000) begin errors++; $display("FAIL load_wmask[%0d]: got %b expected 0000", i, dmem_wmask); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL load_early_valid[%0d]: got %b expected 0", i, valid_out); end
      if (i == 2) begin dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      tick();
      dmem_resp = 1'b0; dmem_rdata = 32'h0;
    end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", valid_out); end
    checks++; if (rdata_out !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h expected deadbeef", rdata_out); end
    checks++; if (regs_out.alu !== 32'h104) begin errors++; $display("FAIL load_alu: got %h expected 00000104", regs_out.alu); end
    checks++; if ({stall_out, dmem_read} !== 2'b00) begin errors++; $display("FAIL load_release: got %b expected 00", {stall_out, dmem_read}); end
    tick();
    checks++; if (valid_out !== 1'b0 || rdata_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_after: valid %b rdata %h expected 0 deadbeef", valid_out, rdata_out); end
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata);
    logic [31:0] prev_rdata;
    prev_rdata = rdata_out;
    regs_in  = make_regs(op_store, alu, rs2, f3, 1'b0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++; if ({dmem_read, dmem_write} !== 2'b01) begin errors++; $display("FAIL store_req(alu=%h): got %b expected 01", alu, {dmem_read, dmem_write}); end
    checks++; if (dmem_address !== exp_addr) begin errors++; $display("FAIL store_addr(alu=%h): got %h expected %h", alu, dmem_address, exp_addr); end
    checks++; if (dmem_wmask !== exp_mask) begin errors++; $display("FAIL store_wmask(alu=%h): got %b expected %b", alu, dmem_wmask, exp_mask); end
    checks++; if (dmem_wdata !== exp_wdata) begin errors++; $display("FAIL store_wdata(alu=%h): got %h expected %h", alu, dmem_wdata, exp_wdata); end
    dmem_resp = 1'b1; dmem_rdata = 32'h5555AAAA;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL store_valid(alu=%h): got %b expected 1", alu, valid_out); end
    checks++; if (rdata_out !== prev_rdata) begin errors++; $display("FAIL store_rdata_kept(alu=%h): got %h expected %h", alu, rdata_out, prev_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    int load_cyc;
    int add_cyc;
    logic consumed;
    pulses = 0; load_cyc = -1; add_cyc = -1;
    regs_in  = make_regs(op_load, 32'h200, 32'h0, 3'b010, 1'b1);
    valid_in = 1'b1;
    tick();
    regs_in  = make_regs(op_reg, 32'h55, 32'h0, 3'b000, 1'b1);
    valid_in = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      dmem_resp  = (cyc == 1);
      dmem_rdata = (cyc == 1) ? 32'hCAFEF00D : 32'h0;
      #1;
      if (cyc <= 1) begin
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 1", cyc, stall_out); end
      end
      consumed = !stall_out && valid_in;
      tick();
      dmem_resp = 1'b0;
      if (consumed) valid_in = 1'b0;
      if (valid_out) begin
        if (pulses == 0) begin
          load_cyc = cyc;
          checks++; if (regs_out.alu !== 32'h200 || rdata_out !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_first: alu %h rdata %h expected 00000200 cafef00d", regs_out.alu, rdata_out); end
        end else if (pulses == 1) begin
          add_cyc = cyc;
          checks++; if (regs_out.alu !== 32'h55) begin errors++; $display("FAIL b2b_second: alu %h expected 00000055", regs_out.alu); end
        end
        pulses++;
      end else begin
        checks++; if (regs_out.ctrl.load_regfile !== 1'b0) begin errors++; $display("FAIL b2b_bubble_lrf[%0d]: got %b expected 0", cyc, regs_out.ctrl.load_regfile); end
      end
    end
    valid_in = 1'b0;
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++; if (load_cyc != 1 || add_cyc != 2) begin errors++; $display("FAIL b2b_timing: load at %0d add at %0d expected 1 2", load_cyc, add_cyc); end
  endtask

  task automatic test_reset_busy();
    regs_in  = make_regs(op_load, 32'h300, 32'h0, 3'b010, 1'b1);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rstbusy_pre_read: got %b expected 1", dmem_read); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({dmem_read, valid_out, stall_out} !== 3'b000) begin
      errors++; $display("FAIL rstbusy_after: read/valid/stall %b expected 000", {dmem_read, valid_out, stall_out}); end
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstbusy_late_resp: got %b expected 0", valid_out); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL rstbusy_rdata: got %h expected 0", rdata_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstbusy_quiet: got %b expected 0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load();
    test_store(3'b000, 32'h1003, 32'h000000AB, 32'h1000, 4'b1000, 32'hAB000000);
    test_store(3'b001, 32'h2002, 32'h00001234, 32'h2000, 4'b1100, 32'h12340000);
    test_store(3'b001, 32'h3003, 32'h0000BEEF, 32'h3000, 4'b1000, 32'hEF000000);
    test_store(3'b010, 32'h4002, 32'h11223344, 32'h4000, 4'b1111, 32'h11223344);
    test_store(3'b000, 32'h5001, 32'hFFFFFF77, 32'h5000, 4'b0010, 32'hFFFF7700);
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
